// File: rtl/relobi_mux_pkg.sv
// Shared types and helpers for the reliable-OBI multiplexer: default OBI
// configuration, TMR'd request/response structs and width helpers.
package relobi_mux_pkg;

    typedef struct packed {
        logic UseRReady;
        logic Integrity;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0, Integrity: 1'b0};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } relobi_a_chan_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } relobi_r_chan_t;

    typedef struct packed {
        logic [2:0]     req;
        logic [2:0]     rready;
        relobi_a_chan_t a;
    } relobi_req_t;

    typedef struct packed {
        logic [2:0]     gnt;
        logic [2:0]     rvalid;
        relobi_r_chan_t r;
    } relobi_rsp_t;

    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    // Voted bundle: {rr_ptr, wr_ptr, rd_ptr, count, push, winner}
    function automatic int unsigned state_width(input int unsigned num_ports,
                                                input int unsigned num_trans);
        return 2 * idx_width(num_ports) + 3 * idx_width(num_trans) + 2;
    endfunction

endpackage

// File: rtl/relobi_mux_tmr_part.sv
// One replica of the reliable-OBI mux control: round-robin arbiter, index
// FIFO for response routing, counters, and the majority voters on next state.
module relobi_mux_tmr_part
    import relobi_mux_pkg::*;
#(
    parameter int unsigned NumSbrPorts = 2,
    parameter int unsigned NumMaxTrans = 4,
    parameter bit          UseRReady   = 1'b0,
    parameter int unsigned IdxWidth    = idx_width(NumSbrPorts),
    parameter int unsigned StateWidth  = state_width(NumSbrPorts, NumMaxTrans)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumSbrPorts-1:0] sbr_req_i,
    input  logic [NumSbrPorts-1:0] sbr_rready_i,
    input  logic                   mgr_gnt_i,
    input  logic                   mgr_rvalid_i,
    input  logic [StateWidth-1:0]  state_a_i,
    input  logic [StateWidth-1:0]  state_b_i,
    output logic [NumSbrPorts-1:0] sbr_gnt_o,
    output logic [NumSbrPorts-1:0] sbr_rvalid_o,
    output logic                   mgr_req_o,
    output logic                   mgr_rready_o,
    output logic [IdxWidth-1:0]    winner_o,
    output logic [StateWidth-1:0]  state_o,
    output logic                   mismatch_o,
    output logic                   spurious_o
);

    localparam int unsigned PtrWidth = idx_width(NumMaxTrans);
    localparam int unsigned CntWidth = PtrWidth + 1;

    logic [IdxWidth-1:0]                  rr_ptr_q, rr_ptr_d, winner, head;
    logic [PtrWidth-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]                  count_q, count_d;
    logic [NumMaxTrans-1:0][IdxWidth-1:0] fifo_q;
    logic                                 any_req, found, full, empty, push, pop;
    int unsigned                          cand;

    logic [StateWidth-1:0] state_vote;
    logic [IdxWidth-1:0]   v_rr_ptr, v_winner;
    logic [PtrWidth-1:0]   v_wr_ptr, v_rd_ptr;
    logic [CntWidth-1:0]   v_count;
    logic                  v_push;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(NumMaxTrans - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Round-robin search starting at rr_ptr, wrapping at NumSbrPorts
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned i = 0; i < NumSbrPorts; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NumSbrPorts) begin
                cand = cand - NumSbrPorts;
            end
            if (!found && sbr_req_i[cand]) begin
                found  = 1'b1;
                winner = IdxWidth'(cand);
            end
        end
    end

    assign any_req   = |sbr_req_i;
    assign full      = (count_q == CntWidth'(NumMaxTrans));
    assign empty     = (count_q == '0);
    assign head      = fifo_q[rd_ptr_q];
    assign mgr_req_o = rst_ni && any_req && !full;
    assign push      = mgr_req_o && mgr_gnt_i;

    // Without UseRReady the subordinate side always accepts responses
    assign mgr_rready_o = UseRReady ? sbr_rready_i[head] : 1'b1;
    assign pop          = rst_ni && mgr_rvalid_i && mgr_rready_o && !empty;
    assign spurious_o   = rst_ni && mgr_rvalid_i && empty;

    always_comb begin
        sbr_gnt_o    = '0;
        sbr_rvalid_o = '0;
        for (int unsigned p = 0; p < NumSbrPorts; p++) begin
            sbr_gnt_o[p]    = push && (winner == IdxWidth'(p));
            sbr_rvalid_o[p] = rst_ni && mgr_rvalid_i && !empty && (head == IdxWidth'(p));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            rr_ptr_d = (winner == IdxWidth'(NumSbrPorts - 1)) ? '0 : winner + 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign state_o    = {rr_ptr_d, wr_ptr_d, rd_ptr_d, count_d, push, winner};
    assign state_vote = (state_o & state_a_i) | (state_o & state_b_i) | (state_a_i & state_b_i);
    assign mismatch_o = rst_ni && (|((state_o ^ state_a_i) | (state_o ^ state_b_i)));
    assign {v_rr_ptr, v_wr_ptr, v_rd_ptr, v_count, v_push, v_winner} = state_vote;
    assign winner_o   = winner;

    // Registers load only voted values so a lone upset replica is outvoted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fifo_q   <= '0;
        end else begin
            rr_ptr_q <= v_rr_ptr;
            wr_ptr_q <= v_wr_ptr;
            rd_ptr_q <= v_rd_ptr;
            count_q  <= v_count;
            if (v_push) begin
                fifo_q[wr_ptr_q] <= v_winner;
            end
        end
    end

endmodule

// File: rtl/relobi_mux.sv
// Reliable-OBI N:1 multiplexer: three voted control replicas arbitrate the
// subordinate ports onto one manager port and route responses in order.
module relobi_mux
    import relobi_mux_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg       = ObiDefaultConfig,
    parameter type         obi_req_t    = relobi_req_t,
    parameter type         obi_rsp_t    = relobi_rsp_t,
    parameter type         obi_r_chan_t = relobi_r_chan_t,
    parameter int unsigned NumSbrPorts  = 2,
    parameter int unsigned NumMaxTrans  = 4,
    parameter int unsigned IdxWidth     = idx_width(NumSbrPorts)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  obi_req_t [NumSbrPorts-1:0] sbr_ports_req_i,
    output obi_rsp_t [NumSbrPorts-1:0] sbr_ports_rsp_o,
    output obi_req_t                   mgr_port_req_o,
    input  obi_rsp_t                   mgr_port_rsp_i,
    output logic [1:0]                 fault_o
);

    localparam int unsigned StateWidth = state_width(NumSbrPorts, NumMaxTrans);

    if (ObiCfg.Integrity) begin : gen_integrity_unsupported
        $fatal(1, "relobi_mux: Integrity=1 is not supported");
    end
    if (NumSbrPorts < 1 || NumMaxTrans < 1) begin : gen_bad_params
        $fatal(1, "relobi_mux: NumSbrPorts and NumMaxTrans must be at least 1");
    end

    logic [2:0][NumSbrPorts-1:0] rep_req, rep_rready, rep_gnt, rep_rvalid;
    logic [2:0][StateWidth-1:0]  rep_state;
    logic [2:0][IdxWidth-1:0]    rep_winner;
    logic [2:0]                  rep_mgr_req, rep_mgr_rready, rep_mismatch, rep_spurious;
    logic [IdxWidth-1:0]         a_vote, a_idx;
    logic                        a_mismatch;
    obi_r_chan_t                 r_bcast;

    // Replica k only ever sees lane k of each triplicated handshake signal
    always_comb begin
        rep_req    = '0;
        rep_rready = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            for (int unsigned p = 0; p < NumSbrPorts; p++) begin
                rep_req[k][p]    = sbr_ports_req_i[p].req[k];
                rep_rready[k][p] = sbr_ports_req_i[p].rready[k];
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : gen_part
        (* dont_touch = "true" *)
        relobi_mux_tmr_part #(
            .NumSbrPorts (NumSbrPorts),
            .NumMaxTrans (NumMaxTrans),
            .UseRReady   (ObiCfg.UseRReady),
            .IdxWidth    (IdxWidth),
            .StateWidth  (StateWidth)
        ) i_part (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .sbr_req_i    (rep_req[k]),
            .sbr_rready_i (rep_rready[k]),
            .mgr_gnt_i    (mgr_port_rsp_i.gnt[k]),
            .mgr_rvalid_i (mgr_port_rsp_i.rvalid[k]),
            .state_a_i    (rep_state[(k + 1) % 3]),
            .state_b_i    (rep_state[(k + 2) % 3]),
            .sbr_gnt_o    (rep_gnt[k]),
            .sbr_rvalid_o (rep_rvalid[k]),
            .mgr_req_o    (rep_mgr_req[k]),
            .mgr_rready_o (rep_mgr_rready[k]),
            .winner_o     (rep_winner[k]),
            .state_o      (rep_state[k]),
            .mismatch_o   (rep_mismatch[k]),
            .spurious_o   (rep_spurious[k])
        );
    end

    assign a_vote = (rep_winner[0] & rep_winner[1]) | (rep_winner[0] & rep_winner[2]) |
                    (rep_winner[1] & rep_winner[2]);
    assign a_mismatch = rst_ni && ((rep_winner[0] != rep_winner[1]) ||
                                   (rep_winner[0] != rep_winner[2]));
    assign a_idx = (int'(a_vote) < NumSbrPorts) ? a_vote : '0;

    always_comb begin
        mgr_port_req_o        = '0;
        mgr_port_req_o.a      = sbr_ports_req_i[a_idx].a;
        mgr_port_req_o.req    = rep_mgr_req;
        mgr_port_req_o.rready = rep_mgr_rready;
    end

    assign r_bcast = mgr_port_rsp_i.r;

    // r data is broadcast; only the head port of each replica sees rvalid
    always_comb begin
        sbr_ports_rsp_o = '0;
        for (int unsigned p = 0; p < NumSbrPorts; p++) begin
            sbr_ports_rsp_o[p].r = r_bcast;
            for (int unsigned k = 0; k < 3; k++) begin
                sbr_ports_rsp_o[p].gnt[k]    = rep_gnt[k][p];
                sbr_ports_rsp_o[p].rvalid[k] = rep_rvalid[k][p];
            end
        end
    end

    assign fault_o[0] = (|rep_mismatch) | a_mismatch;
    assign fault_o[1] = |rep_spurious;

endmodule
